regfile_arbiter: RTL and testbench

Arbitrates access to the 8×16 general-purpose register file between the CPU datapath and a debug/monitor port (switch/hex-display debug interface). The CPU has priority, and a bounded wait counter guarantees the debug port eventually gets a slot. Debug reads use the SR2 read port and are captured in a holding register. Debug writes use the single write port. The block sits between the control unit/datapath and the register file and drives the file's LD_REG, DR, SR1, SR2 and data inputs.

---
 rtl/regfile_arbiter.sv | 94 +++++++++
 tb/tb_regfile_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// Register-file port arbiter: CPU datapath vs debug/monitor port.
// Optional REGFILE_ARB_DBG_WR_EN enables debug writes into the file.
module regfile_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CPU_Req,
  input  logic        CPU_Wr,
  input  logic [2:0]  CPU_DR,
  input  logic [2:0]  CPU_SR1,
  input  logic [2:0]  CPU_SR2,
  input  logic [15:0] CPU_Data,
  output logic        CPU_Gnt,
  input  logic        DBG_Req,
  input  logic        DBG_Wr,
  input  logic [2:0]  DBG_Addr,
  input  logic [15:0] DBG_WData,
  output logic        DBG_Ack,
  output logic [15:0] DBG_RData,
  output logic        LD_REG,
  output logic [2:0]  DR,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic [15:0] RF_In,
  input  logic [15:0] SR2_Out
);

  typedef enum logic {IDLE, ACK} state_t;

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       dbg_gnt;
  logic       dbg_ld;
  logic [15:0] dbg_wdata;

`ifdef REGFILE_ARB_DBG_WR_EN
  assign dbg_ld    = DBG_Wr;
  assign dbg_wdata = DBG_WData;
`else
  logic unused_wdata;
  assign unused_wdata = ^DBG_WData;
  assign dbg_ld       = 1'b0;
  assign dbg_wdata    = CPU_Data;
`endif

  // Reset gates the grants so nothing loads while held in reset.
  assign dbg_gnt = Reset & (state == IDLE) & DBG_Req
                 & (~CPU_Req | (wait_cnt == MAX_W));
  assign CPU_Gnt = Reset & CPU_Req & ~dbg_gnt;

  assign SR1    = CPU_SR1;
  assign SR2    = dbg_gnt ? DBG_Addr : CPU_SR2;
  assign DR     = dbg_gnt ? DBG_Addr : CPU_DR;
  assign RF_In  = dbg_gnt ? dbg_wdata : CPU_Data;
  assign LD_REG = dbg_gnt ? dbg_ld
                          : (Reset & CPU_Req & CPU_Wr);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      DBG_Ack   <= 1'b0;
      DBG_RData <= 16'h0000;
    end else begin
      DBG_Ack <= dbg_gnt;
      unique case (state)
        IDLE: begin
          if (dbg_gnt) begin
            state    <= ACK;
            wait_cnt <= 8'd0;
            if (!DBG_Wr)
              DBG_RData <= SR2_Out;
          end else if (!DBG_Req) begin
            wait_cnt <= 8'd0;
          end else if (wait_cnt != MAX_W) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ACK: begin
          state    <= IDLE;
          wait_cnt <= 8'd0;
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed steps plus random traffic vs a
// cycle model of the arbitration rules and a model register file.
module tb_regfile_arbiter;

  localparam int MAX_WAIT = 4;
`ifdef REGFILE_ARB_DBG_WR_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic        Clk;
  logic        Reset;
  logic        CPU_Req, CPU_Wr;
  logic [2:0]  CPU_DR, CPU_SR1, CPU_SR2;
  logic [15:0] CPU_Data;
  logic        CPU_Gnt;
  logic        DBG_Req, DBG_Wr;
  logic [2:0]  DBG_Addr;
  logic [15:0] DBG_WData;
  logic        DBG_Ack;
  logic [15:0] DBG_RData;
  logic        LD_REG;
  logic [2:0]  DR, SR1, SR2;
  logic [15:0] RF_In, SR2_Out;

  regfile_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .Clk(Clk), .Reset(Reset),
    .CPU_Req(CPU_Req), .CPU_Wr(CPU_Wr),
    .CPU_DR(CPU_DR), .CPU_SR1(CPU_SR1), .CPU_SR2(CPU_SR2),
    .CPU_Data(CPU_Data), .CPU_Gnt(CPU_Gnt),
    .DBG_Req(DBG_Req), .DBG_Wr(DBG_Wr), .DBG_Addr(DBG_Addr),
    .DBG_WData(DBG_WData), .DBG_Ack(DBG_Ack), .DBG_RData(DBG_RData),
    .LD_REG(LD_REG), .DR(DR), .SR1(SR1), .SR2(SR2),
    .RF_In(RF_In), .SR2_Out(SR2_Out)
  );

  // The register file the arbiter drives.
  logic [15:0] tb_rf [8];
  always_ff @(posedge Clk)
    if (LD_REG) tb_rf[DR] <= RF_In;
  assign SR2_Out = tb_rf[SR2];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: ack pending, blocked-cycle count, read data, file.
  bit          m_ack;
  int          m_wait;
  logic [15:0] m_rdata;
  logic [15:0] m_rf [8];
  bit          rf_valid = 0;
  bit          last_cgnt;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [15:0] a [8]);
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[i*16 +: 16] = a[i];
    return v;
  endfunction

  task automatic mreset();
    m_ack   = 0;
    m_wait  = 0;
    m_rdata = 16'h0000;
  endtask

  task automatic step();
    bit dg, cg, ld;
    if (!Reset) mreset();
    @(negedge Clk);
    dg = Reset && !m_ack && DBG_Req
       && (!CPU_Req || m_wait >= MAX_WAIT);
    cg = Reset && CPU_Req && !dg;
    ld = dg ? (WR_EN && DBG_Wr) : (Reset && CPU_Req && CPU_Wr);
    last_cgnt = CPU_Gnt;
    chk("cpu_gnt", CPU_Gnt, cg);
    chk("ld_reg", LD_REG, ld);
    chk("sr1", SR1, CPU_SR1);
    chk("sr2", SR2, dg ? DBG_Addr : CPU_SR2);
    chk("dr", DR, dg ? DBG_Addr : CPU_DR);
    if (ld) chk("rf_in", RF_In, dg ? DBG_WData : CPU_Data);
    @(posedge Clk);
    #1;
    if (!Reset) begin
      mreset();
    end else begin
      if (dg) begin
        if (!DBG_Wr) m_rdata = m_rf[DBG_Addr];
        else if (WR_EN) m_rf[DBG_Addr] = DBG_WData;
        m_wait = 0;
      end else begin
        if (ld) m_rf[CPU_DR] = CPU_Data;
        if (!DBG_Req) m_wait = 0;
        else if (!m_ack && m_wait < MAX_WAIT) m_wait++;
      end
      m_ack = dg;
    end
    chk("dbg_ack", DBG_Ack, m_ack);
    chk("dbg_rdata", DBG_RData, m_rdata);
    if (rf_valid) chk("rf", pack(tb_rf), pack(m_rf));
  endtask

  initial begin
    int n, acks;
    bit seen;
    Reset = 0;
    {CPU_Req, CPU_Wr, DBG_Req, DBG_Wr} = '0;
    {CPU_DR, CPU_SR1, CPU_SR2, DBG_Addr} = '0;
    CPU_Data = '0;
    DBG_WData = '0;
    mreset();
    // Held in reset with requests present: nothing granted.
    step();
    CPU_Req = 1; CPU_Wr = 1; DBG_Req = 1;
    step();
    {CPU_Req, CPU_Wr, DBG_Req} = '0;
    Reset = 1;

    // Preload the file through CPU writes.
    for (int i = 0; i < 8; i++) begin
      CPU_Req = 1; CPU_Wr = 1; CPU_DR = 3'(i);
      CPU_Data = (i == 3) ? 16'h1234 : 16'(i * 16'h1111);
      step();
    end
    CPU_Req = 0; CPU_Wr = 0;
    rf_valid = 1;

    // Debug read with CPU idle: grant now, ack next.
    DBG_Req = 1; DBG_Wr = 0; DBG_Addr = 3;
    step();
    DBG_Req = 0;
    step();
    chk("rd_r3", DBG_RData, 16'h1234);

    // CPU busy: debug waits MAX_WAIT cycles.
    CPU_Req = 1; CPU_Wr = 0; CPU_SR2 = 6;
    DBG_Req = 1; DBG_Wr = 0; DBG_Addr = 1;
    n = 0; seen = 0;
    for (int k = 0; k < 12 && !m_ack; k++) begin
      step();
      if (last_cgnt && !seen) n++;
      else seen = 1;
    end
    chk("cpu_wait", n, MAX_WAIT);
    DBG_Req = 0;
    step();

    // Same-register collision.
    CPU_Wr = 1; CPU_DR = 5; CPU_Data = 16'h0001;
    DBG_Req = 1; DBG_Wr = 1; DBG_Addr = 5; DBG_WData = 16'hBEEF;
    for (int k = 0; k < 12 && !m_ack; k++) step();
    chk("r5_grant", tb_rf[5], WR_EN ? 16'hBEEF : 16'h0001);
    DBG_Req = 0;
    step();
    chk("r5_after", tb_rf[5], 16'h0001);
    CPU_Req = 0; CPU_Wr = 0;

    // Back-to-back reads with request held.
    DBG_Req = 1; DBG_Wr = 0; DBG_Addr = 2;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (DBG_Ack) acks++;
    end
    chk("b2b_acks", acks, 3);
    DBG_Req = 0;
    step();

    // Reset pulsed inside a debug-write grant.
    DBG_Req = 1; DBG_Wr = 1; DBG_Addr = 4; DBG_WData = 16'hDEAD;
    #2;
    chk("rst_ld_pre", LD_REG, WR_EN);
    chk("rst_dr_pre", DR, 3'd4);
    Reset = 0;
    #1;
    chk("rst_ld", LD_REG, 1'b0);
    step();
    DBG_Req = 0;
    Reset = 1;
    step();
    chk("rst_r4", tb_rf[4], 16'h4444);

    // Debug write of R2.
    DBG_Req = 1; DBG_Wr = 1; DBG_Addr = 2; DBG_WData = 16'hFFFF;
    step();
    DBG_Req = 0;
    step();
    chk("wr_r2", tb_rf[2], WR_EN ? 16'hFFFF : 16'h2222);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      CPU_Req  = ($urandom % 10) < 7;
      CPU_Wr   = $urandom % 2;
      CPU_DR   = 3'($urandom);
      CPU_SR1  = 3'($urandom);
      CPU_SR2  = 3'($urandom);
      CPU_Data = 16'($urandom);
      if (!DBG_Req || m_ack) begin
        if (DBG_Req && ($urandom % 2) == 0) begin
          DBG_Req = 0;
        end else if ($urandom % 3 == 0) begin
          DBG_Req   = 1;
          DBG_Wr    = $urandom % 2;
          DBG_Addr  = 3'($urandom);
          DBG_WData = 16'($urandom);
        end else begin
          DBG_Req = 0;
        end
      end else if ($urandom % 20 == 0) begin
        DBG_Req = 0;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
